// File: rtl/sram_arbiter_if.sv
// Bundle of the two core-side request ports and the shared single-port sram pins.
// The arbiter takes the slave view; the environment (core + sram) takes the master view.
interface sram_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              p0_req;
  logic [ADDR_W-1:0] p0_addr;
  logic [DATA_W-1:0] p0_wdata;
  logic [3:0]        p0_b_en;
  logic              p0_w_en;
  logic              p0_gnt;
  logic              p0_rvalid;
  logic [DATA_W-1:0] p0_rdata;
  logic              p0_error;

  logic              p1_req;
  logic [ADDR_W-1:0] p1_addr;
  logic [DATA_W-1:0] p1_wdata;
  logic [3:0]        p1_b_en;
  logic              p1_w_en;
  logic              p1_gnt;
  logic              p1_rvalid;
  logic [DATA_W-1:0] p1_rdata;
  logic              p1_error;

  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [3:0]        mem_b_en;
  logic              mem_w_en;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_stall;
  logic              mem_error;

  modport slave (
    input  p0_req, p0_addr, p0_wdata, p0_b_en, p0_w_en,
    output p0_gnt, p0_rvalid, p0_rdata, p0_error,
    input  p1_req, p1_addr, p1_wdata, p1_b_en, p1_w_en,
    output p1_gnt, p1_rvalid, p1_rdata, p1_error,
    output mem_addr, mem_wdata, mem_b_en, mem_w_en,
    input  mem_rdata, mem_stall, mem_error
  );

  modport master (
    output p0_req, p0_addr, p0_wdata, p0_b_en, p0_w_en,
    input  p0_gnt, p0_rvalid, p0_rdata, p0_error,
    output p1_req, p1_addr, p1_wdata, p1_b_en, p1_w_en,
    input  p1_gnt, p1_rvalid, p1_rdata, p1_error,
    input  mem_addr, mem_wdata, mem_b_en, mem_w_en,
    output mem_rdata, mem_stall, mem_error
  );
endinterface

// File: rtl/sram_arbiter.sv
// Round-robin arbiter sharing one single-port sram between instruction fetch (port 0)
// and load/store (port 1); one transaction in flight, grant may overlap the response cycle.
module sram_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic          gclk,
  input  logic          resetn,
  sram_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, RESP = 2'd2} state_t;

  state_t            state_q, state_d;
  logic              owner_q, owner_d;
  logic              pref_q, pref_d;
  logic              err_q, err_d;
  logic              zero_q, zero_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [3:0]        ben_q, ben_d;
  logic              wen_q, wen_d;
  logic              gnt0, gnt1, can_gnt;
  logic              rv0, rv1;
  logic [DATA_W-1:0] resp_data;

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    pref_d  = pref_q;
    err_d   = err_q;
    zero_d  = zero_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    ben_d   = ben_q;
    wen_d   = wen_q;
    gnt0    = 1'b0;
    gnt1    = 1'b0;
    // pref_q names the port that wins when both ports request
    can_gnt = resetn && (state_q != ISSUE);
    if (can_gnt) begin
      if (bus.p0_req && (!bus.p1_req || !pref_q)) gnt0 = 1'b1;
      else if (bus.p1_req)                        gnt1 = 1'b1;
    end
    case (state_q)
      ISSUE: begin
        if (!bus.mem_stall) begin
          err_d   = bus.mem_error;
          zero_d  = wen_q || (ben_q == 4'h0);
          ben_d   = 4'h0;
          wen_d   = 1'b0;
          state_d = RESP;
        end
      end
      RESP:    state_d = IDLE;
      default: ;
    endcase
    // A grant in RESP starts the next transaction on the same edge the response retires
    if (gnt0 || gnt1) begin
      owner_d = gnt1;
      pref_d  = gnt0;
      addr_d  = gnt1 ? bus.p1_addr  : bus.p0_addr;
      wdata_d = gnt1 ? bus.p1_wdata : bus.p0_wdata;
      ben_d   = gnt1 ? bus.p1_b_en  : bus.p0_b_en;
      wen_d   = gnt1 ? bus.p1_w_en  : bus.p0_w_en;
      state_d = ISSUE;
    end
  end

  always_ff @(posedge gclk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      owner_q <= 1'b0;
      pref_q  <= 1'b0;
      err_q   <= 1'b0;
      zero_q  <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      ben_q   <= 4'h0;
      wen_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      pref_q  <= pref_d;
      err_q   <= err_d;
      zero_q  <= zero_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      ben_q   <= ben_d;
      wen_q   <= wen_d;
    end
  end

  // Writes and empty byte-enable accesses return zero data; errors still pass through
  assign resp_data = zero_q ? '0 : bus.mem_rdata;
  assign rv0       = (state_q == RESP) && !owner_q;
  assign rv1       = (state_q == RESP) && owner_q;

  assign bus.p0_gnt    = gnt0;
  assign bus.p1_gnt    = gnt1;
  assign bus.p0_rvalid = rv0;
  assign bus.p1_rvalid = rv1;
  assign bus.p0_rdata  = rv0 ? resp_data : '0;
  assign bus.p1_rdata  = rv1 ? resp_data : '0;
  assign bus.p0_error  = rv0 && err_q;
  assign bus.p1_error  = rv1 && err_q;

  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.mem_b_en  = ben_q;
  assign bus.mem_w_en  = wen_q;
endmodule

// File: tb/tb_sram_arbiter.sv
// Bench for sram_arbiter: table-driven arbitration vectors, hand-written corner sequences,
// and randomized traffic checked against a transaction-level model with a golden memory.
module tb_sram_arbiter;
  logic gclk = 1'b0;
  logic resetn = 1'b0;
  always #5 gclk = ~gclk;

  sram_arbiter_if #(.ADDR_W(32), .DATA_W(32)) b ();
  sram_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (.gclk(gclk), .resetn(resetn), .bus(b));

  int n_chk = 0;
  int n_fail = 0;

  // sram model: 64 words, registered read data, combinational out-of-range error
  logic [31:0] sram [0:63];
  logic [31:0] srd = 32'h0;
  logic        ld_en = 1'b0;
  logic [5:0]  ld_idx = 6'd0;
  logic [31:0] ld_val = 32'h0;
  always @(posedge gclk) begin
    if (ld_en) sram[ld_idx] <= ld_val;
    else if (b.mem_b_en != 4'h0 && !b.mem_stall) begin
      if (b.mem_addr >= 32'd256) begin
        if (!b.mem_w_en) srd <= 32'hBADDCAFE;
      end else if (b.mem_w_en) begin
        for (int k = 0; k < 4; k++)
          if (b.mem_b_en[k]) sram[b.mem_addr[7:2]][8*k +: 8] <= b.mem_wdata[8*k +: 8];
      end else srd <= sram[b.mem_addr[7:2]];
    end
  end
  assign b.mem_rdata = srd;
  assign b.mem_error = (b.mem_b_en != 4'h0) && (b.mem_addr >= 32'd256);

  // Golden memory and expected-response rules
  logic [31:0] gold [0:63];
  function automatic void ref_access(input logic [31:0] a, input logic [31:0] wd,
                                     input logic [3:0] be, input logic we,
                                     output logic [31:0] rd, output logic er);
    rd = 32'h0;
    er = 1'b0;
    if (be != 4'h0) begin
      if (a >= 32'd256) begin
        er = 1'b1;
        if (!we) rd = 32'hBADDCAFE;
      end else if (we) begin
        for (int k = 0; k < 4; k++) if (be[k]) gold[a[7:2]][8*k +: 8] = wd[8*k +: 8];
      end else rd = gold[a[7:2]];
    end
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Requester state, driven onto the bus once per cycle
  logic [1:0]  rq = 2'b00;
  logic [31:0] ra [2];
  logic [31:0] rw [2];
  logic [3:0]  rb [2];
  logic        re [2];
  logic        st = 1'b0;

  task automatic apply();
    b.p0_req = rq[0]; b.p0_addr = ra[0]; b.p0_wdata = rw[0]; b.p0_b_en = rb[0]; b.p0_w_en = re[0];
    b.p1_req = rq[1]; b.p1_addr = ra[1]; b.p1_wdata = rw[1]; b.p1_b_en = rb[1]; b.p1_w_en = re[1];
    b.mem_stall = st;
  endtask

  task automatic setp(input int p, input logic [31:0] a, input logic [31:0] wd,
                      input logic [3:0] be, input logic we);
    ra[p] = a; rw[p] = wd; rb[p] = be; re[p] = we;
  endtask

  // Drive one cycle just after the rising edge, then settle to the sample point
  task automatic cyc(input logic r0, input logic r1, input logic s);
    @(posedge gclk);
    #1;
    rq = {r1, r0};
    st = s;
    apply();
    #3;
  endtask

  typedef struct {
    logic r0, r1, st;
    logic g0, g1, v0, v1;
    logic [3:0]  ben;
    logic [31:0] addr, rd0, rd1;
  } vec_t;
  vec_t tv [19];

  logic [31:0] erd, tmp_rd;
  logic        eer, tmp_er;
  logic        m_issue, m_resp, m_port, m_last;
  logic [31:0] m_rd;
  logic        m_er;
  logic [1:0]  eg;

  initial begin
    setp(0, 32'h10, 32'h0, 4'hF, 1'b0);
    setp(1, 32'h20, 32'h0, 4'hF, 1'b0);
    rq = 2'b00; st = 1'b0;
    apply();

    // Preload while reset is held
    for (int i = 0; i < 64; i++) begin
      @(posedge gclk);
      #1;
      ld_en = 1'b1;
      ld_idx = 6'(i);
      ld_val = (i == 4) ? 32'hDEADBEEF : (i == 8) ? 32'hCAFEF00D : $urandom;
      gold[i] = ld_val;
    end
    @(posedge gclk);
    #1;
    ld_en = 1'b0;
    #3;
    chk("rst mem_addr", b.mem_addr, 32'h0);
    chk("rst mem_wdata", b.mem_wdata, 32'h0);
    chk("rst mem_b_en", {28'h0, b.mem_b_en}, 32'h0);
    chk("rst mem_w_en", {31'h0, b.mem_w_en}, 32'h0);
    chk("rst rvalid", {30'h0, b.p1_rvalid, b.p0_rvalid}, 32'h0);
    chk("rst rdata0", b.p0_rdata, 32'h0);
    chk("rst rdata1", b.p1_rdata, 32'h0);
    resetn = 1'b1;

    tv[0]  = '{1,1,0, 1,0,0,0, 4'h0, 32'h00, 32'h0, 32'h0};
    tv[1]  = '{0,1,0, 0,0,0,0, 4'hF, 32'h10, 32'h0, 32'h0};
    tv[2]  = '{1,1,0, 0,1,1,0, 4'h0, 32'h00, 32'hDEADBEEF, 32'h0};
    tv[3]  = '{1,0,0, 0,0,0,0, 4'hF, 32'h20, 32'h0, 32'h0};
    tv[4]  = '{1,0,0, 1,0,0,1, 4'h0, 32'h00, 32'h0, 32'hCAFEF00D};
    tv[5]  = '{0,1,1, 0,0,0,0, 4'hF, 32'h10, 32'h0, 32'h0};
    tv[6]  = '{0,1,1, 0,0,0,0, 4'hF, 32'h10, 32'h0, 32'h0};
    tv[7]  = '{0,1,1, 0,0,0,0, 4'hF, 32'h10, 32'h0, 32'h0};
    tv[8]  = '{0,1,0, 0,0,0,0, 4'hF, 32'h10, 32'h0, 32'h0};
    tv[9]  = '{0,1,0, 0,1,1,0, 4'h0, 32'h00, 32'hDEADBEEF, 32'h0};
    tv[10] = '{0,0,0, 0,0,0,0, 4'hF, 32'h20, 32'h0, 32'h0};
    tv[11] = '{0,0,0, 0,0,0,1, 4'h0, 32'h00, 32'h0, 32'hCAFEF00D};
    tv[12] = '{0,0,0, 0,0,0,0, 4'h0, 32'h00, 32'h0, 32'h0};
    tv[13] = '{0,1,0, 0,1,0,0, 4'h0, 32'h00, 32'h0, 32'h0};
    tv[14] = '{1,0,0, 0,0,0,0, 4'hF, 32'h20, 32'h0, 32'h0};
    tv[15] = '{1,0,0, 1,0,0,1, 4'h0, 32'h00, 32'h0, 32'hCAFEF00D};
    tv[16] = '{0,0,0, 0,0,0,0, 4'hF, 32'h10, 32'h0, 32'h0};
    tv[17] = '{0,0,0, 0,0,1,0, 4'h0, 32'h00, 32'hDEADBEEF, 32'h0};
    tv[18] = '{0,0,0, 0,0,0,0, 4'h0, 32'h00, 32'h0, 32'h0};
    for (int i = 0; i < 19; i++) begin
      cyc(tv[i].r0, tv[i].r1, tv[i].st);
      chk($sformatf("tv%0d gnt", i), {30'h0, b.p1_gnt, b.p0_gnt}, {30'h0, tv[i].g1, tv[i].g0});
      chk($sformatf("tv%0d rvalid", i), {30'h0, b.p1_rvalid, b.p0_rvalid}, {30'h0, tv[i].v1, tv[i].v0});
      chk($sformatf("tv%0d mem_b_en", i), {28'h0, b.mem_b_en}, {28'h0, tv[i].ben});
      if (tv[i].ben != 4'h0) chk($sformatf("tv%0d mem_addr", i), b.mem_addr, tv[i].addr);
      chk($sformatf("tv%0d rdata0", i), b.p0_rdata, tv[i].rd0);
      chk($sformatf("tv%0d rdata1", i), b.p1_rdata, tv[i].rd1);
    end

    // Port 1 partial write then read-back of the low half
    setp(1, 32'h8, 32'h12345678, 4'b0011, 1'b1);
    ref_access(32'h8, 32'h12345678, 4'b0011, 1'b1, tmp_rd, tmp_er);
    cyc(0, 1, 0); chk("wr gnt1", {31'h0, b.p1_gnt}, 32'h1);
    cyc(0, 0, 0);
    chk("wr mem_w_en", {31'h0, b.mem_w_en}, 32'h1);
    chk("wr mem_b_en", {28'h0, b.mem_b_en}, 32'h3);
    chk("wr mem_wdata", b.mem_wdata, 32'h12345678);
    chk("wr mem_addr", b.mem_addr, 32'h8);
    cyc(0, 0, 0);
    chk("wr rvalid1", {31'h0, b.p1_rvalid}, 32'h1);
    chk("wr rdata1", b.p1_rdata, 32'h0);
    chk("wr mem_w_en off", {31'h0, b.mem_w_en}, 32'h0);
    setp(1, 32'h8, 32'h0, 4'hF, 1'b0);
    ref_access(32'h8, 32'h0, 4'hF, 1'b0, tmp_rd, tmp_er);
    cyc(0, 1, 0); chk("rd gnt1", {31'h0, b.p1_gnt}, 32'h1);
    cyc(0, 0, 0); chk("rd mem_w_en", {31'h0, b.mem_w_en}, 32'h0);
    cyc(0, 0, 0);
    chk("rd rvalid1", {31'h0, b.p1_rvalid}, 32'h1);
    chk("rd low half", {16'h0, b.p1_rdata[15:0]}, 32'h5678);

    // Out-of-range read reports error with data passed through, then an in-range read clears it
    setp(0, 32'h400, 32'h0, 4'hF, 1'b0);
    cyc(1, 0, 0); chk("err gnt0", {31'h0, b.p0_gnt}, 32'h1);
    cyc(0, 0, 0);
    cyc(0, 0, 0);
    chk("err rvalid0", {31'h0, b.p0_rvalid}, 32'h1);
    chk("err error0", {31'h0, b.p0_error}, 32'h1);
    chk("err rdata0", b.p0_rdata, 32'hBADDCAFE);
    setp(0, 32'h10, 32'h0, 4'hF, 1'b0);
    cyc(1, 0, 0);
    cyc(0, 0, 0);
    cyc(0, 0, 0);
    chk("ok rvalid0", {31'h0, b.p0_rvalid}, 32'h1);
    chk("ok error0", {31'h0, b.p0_error}, 32'h0);
    chk("ok rdata0", b.p0_rdata, 32'hDEADBEEF);

    // Empty byte-enable request completes with zero data even though the sram data is stale
    setp(1, 32'h20, 32'h0, 4'h0, 1'b0);
    cyc(0, 1, 0); chk("ben0 gnt1", {31'h0, b.p1_gnt}, 32'h1);
    cyc(0, 0, 0); chk("ben0 mem_b_en", {28'h0, b.mem_b_en}, 32'h0);
    cyc(0, 0, 0);
    chk("ben0 rvalid1", {31'h0, b.p1_rvalid}, 32'h1);
    chk("ben0 rdata1", b.p1_rdata, 32'h0);
    chk("ben0 error1", {31'h0, b.p1_error}, 32'h0);
    cyc(0, 0, 0);

    // Randomized traffic against the transaction-level model; last grant went to port 1
    m_issue = 1'b0; m_resp = 1'b0; m_port = 1'b0; m_last = 1'b1; m_rd = 32'h0; m_er = 1'b0;
    rq = 2'b00;
    for (int c = 0; c < 1500; c++) begin
      @(posedge gclk);
      #1;
      for (int p = 0; p < 2; p++) begin
        if (!rq[p] && $urandom_range(0, 2) == 0) begin
          rq[p] = 1'b1;
          ra[p] = ($urandom_range(0, 9) == 0) ? 32'h100 + 32'($urandom_range(0, 15)) * 4
                                              : 32'($urandom_range(0, 7)) * 4;
          rw[p] = $urandom;
          rb[p] = 4'($urandom_range(0, 15));
          re[p] = 1'($urandom_range(0, 1));
        end else if (rq[p] && $urandom_range(0, 15) == 0) rq[p] = 1'b0;
      end
      st = ($urandom_range(0, 3) == 0);
      apply();
      #3;
      eg = 2'b00;
      if (!m_issue) begin
        if (rq[0] && rq[1]) eg = m_last ? 2'b01 : 2'b10;
        else if (rq[0])     eg = 2'b01;
        else if (rq[1])     eg = 2'b10;
      end
      chk($sformatf("rnd%0d gnt", c), {30'h0, b.p1_gnt, b.p0_gnt}, {30'h0, eg});
      chk($sformatf("rnd%0d rvalid", c), {30'h0, b.p1_rvalid, b.p0_rvalid},
          {30'h0, m_resp && m_port, m_resp && !m_port});
      chk($sformatf("rnd%0d rdata0", c), b.p0_rdata, (m_resp && !m_port) ? m_rd : 32'h0);
      chk($sformatf("rnd%0d rdata1", c), b.p1_rdata, (m_resp && m_port) ? m_rd : 32'h0);
      chk($sformatf("rnd%0d error0", c), {31'h0, b.p0_error}, {31'h0, m_resp && !m_port && m_er});
      chk($sformatf("rnd%0d error1", c), {31'h0, b.p1_error}, {31'h0, m_resp && m_port && m_er});
      m_resp = m_issue && !st;
      m_issue = m_issue && st;
      if (eg != 2'b00) begin
        m_port = eg[1];
        m_last = eg[1];
        ref_access(ra[m_port], rw[m_port], rb[m_port], re[m_port], m_rd, m_er);
        rq[m_port] = 1'b0;
        m_issue = 1'b1;
      end
    end

    // Drain, then reset in the middle of a stalled ISSUE
    for (int i = 0; i < 8; i++) cyc(0, 0, 0);
    setp(0, 32'h10, 32'h0, 4'hF, 1'b0);
    setp(1, 32'h20, 32'h0, 4'hF, 1'b0);
    cyc(1, 0, 0); chk("prerst gnt0", {31'h0, b.p0_gnt}, 32'h1);
    cyc(0, 1, 1);
    chk("prerst mem_b_en", {28'h0, b.mem_b_en}, 32'hF);
    chk("prerst no gnt", {30'h0, b.p1_gnt, b.p0_gnt}, 32'h0);
    #1;
    resetn = 1'b0;
    #1;
    chk("inrst mem_addr", b.mem_addr, 32'h0);
    chk("inrst mem_b_en", {28'h0, b.mem_b_en}, 32'h0);
    chk("inrst gnt", {30'h0, b.p1_gnt, b.p0_gnt}, 32'h0);
    cyc(1, 1, 0);
    chk("inrst2 gnt", {30'h0, b.p1_gnt, b.p0_gnt}, 32'h0);
    chk("inrst2 rvalid", {30'h0, b.p1_rvalid, b.p0_rvalid}, 32'h0);
    @(posedge gclk);
    #1;
    resetn = 1'b1;
    #3;
    chk("postrst gnt", {30'h0, b.p1_gnt, b.p0_gnt}, 32'h1);
    chk("postrst rvalid", {30'h0, b.p1_rvalid, b.p0_rvalid}, 32'h0);
    ref_access(32'h10, 32'h0, 4'hF, 1'b0, erd, eer);
    cyc(0, 1, 0);
    chk("postrst issue rvalid", {30'h0, b.p1_rvalid, b.p0_rvalid}, 32'h0);
    cyc(0, 1, 0);
    chk("postrst resp rvalid", {30'h0, b.p1_rvalid, b.p0_rvalid}, 32'h1);
    chk("postrst resp rdata0", b.p0_rdata, erd);
    cyc(0, 0, 0);
    cyc(0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
